// File: rtl/data_mem_responder.sv
// data_mem_responder: target side of the CPU data-memory port.
// Accepts one load/store at a time, waits WAIT_STATES cycles, performs the
// access on a single edge and holds the response until the requester takes it.
module data_mem_responder #(
   parameter int WAIT_STATES = 2,
   parameter int WORD_LO     = 250,
   parameter int WORD_HI     = 2499
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int DEPTH = WORD_HI - WORD_LO + 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        write_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   // Only the legal word window is backed by storage.
   logic [31:0] mem [DEPTH];

   logic [29:0]   word;
   logic [AW-1:0] idx;
   logic          err;
   logic          access;
   logic          mem_we;

   // Full 30-bit unsigned word index, so huge addresses never wrap into range.
   assign word   = addr_q[31:2];
   assign idx    = AW'(word - 30'(WORD_LO));
   assign err    = (addr_q[1:0] != 2'b00) ||
                   (word < 30'(WORD_LO)) || (word > 30'(WORD_HI));
   assign access = (state == WAIT) && (cnt == 4'd0);
   assign mem_we = access && write_q && !err;

   // Memory array: no reset, a write commits only on the access edge.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= wdata_q;
   end

   // Request/response FSM with registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // req_ready is high throughout IDLE, so req_valid alone accepts.
               if (req_valid) begin
                  write_q   <= req_write;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  cnt       <= 4'(WAIT_STATES);
                  req_ready <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= err;
                  rsp_rdata <= (err || write_q) ? 32'd0 : mem[idx];
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-map reference model.
module tb_data_mem_responder;

   localparam int WS = 2;
   localparam int LO = 250;
   localparam int HI = 2499;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr  = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int nvec = 0;
   int nerr = 0;

   // Reference memory: only words the bench has stored are ever read back.
   logic [31:0] model [logic [29:0]];

   data_mem_responder #(.WAIT_STATES(WS), .WORD_LO(LO), .WORD_HI(HI)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
      chk({tag, "_vld"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rd"},  rsp_rdata, 32'd0);
      chk({tag, "_err"}, 32'(rsp_err), 32'd0);
   endtask

   // One full transaction with optional response back-pressure.
   task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d, input int stall);
      logic [29:0] w;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          lat;
      int          g;
      w       = a[31:2];
      exp_err = (a[1:0] != 2'b00) || (w < 30'(LO)) || (w > 30'(HI));
      exp_rd  = 32'd0;
      if (!exp_err && !wr && model.exists(w)) exp_rd = model[w];

      @(negedge clk);
      g = 0;
      while (!req_ready && g < 20) begin @(negedge clk); g++; end
      chk("accept_rdy", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1;
      // Scramble inputs after acceptance; they must have no effect.
      req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;

      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (rsp_valid) break;
         @(posedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(WS + 1));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      if (!exp_err && wr) model[w] = d;

      for (int i = 0; i < stall; i++) begin
         // A competing store to word LO must be ignored while busy.
         req_valid = 1'b1; req_write = 1'b1; req_addr = 32'(LO) << 2; req_wdata = $urandom;
         @(posedge clk);
         @(negedge clk);
         chk("stall_vld", 32'(rsp_valid), 32'd1);
         chk("stall_rdy", 32'(req_ready), 32'd0);
         chk("stall_rd", rsp_rdata, exp_rd);
         chk("stall_err", 32'(rsp_err), 32'(exp_err));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk_idle("post");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [29:0] w;
      logic [31:0] a;
      logic        wr;
      int          k;

      // Power-up reset.
      repeat (2) @(negedge clk);
      chk_idle("rst0");
      rst = 1'b0;

      // Store then load at word 250.
      txn(1'b1, 32'h3E8, 32'd2, 0);
      txn(1'b0, 32'h3E8, 32'd0, 0);

      // Error cases, then confirm no corruption.
      txn(1'b0, 32'h3EA, 32'd0, 0);
      txn(1'b1, 32'h10, 32'h1234_5678, 0);
      txn(1'b1, 32'h3EA, 32'hBAD0_BAD0, 0);
      txn(1'b0, 32'h3E8, 32'd0, 0);

      // Window boundaries.
      txn(1'b1, 32'h270C, 32'hCAFE_F00D, 0);
      txn(1'b0, 32'h270C, 32'd0, 0);
      txn(1'b1, 32'h2710, 32'h1111_1111, 0);
      txn(1'b0, 32'h2710, 32'd0, 0);
      txn(1'b1, 32'hFFFF_FFFC, 32'h2222_2222, 0);

      // Back-pressure for 5 cycles.
      txn(1'b0, 32'h270C, 32'd0, 5);
      txn(1'b0, 32'h3E8, 32'd0, 0);

      // Mid-cycle reset while idle.
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_idle("rst_mid");
      @(negedge clk) rst = 1'b0;

      // Reset during WAIT of a store: the store must be dropped.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3E8; req_wdata = 32'h0000_DEAD;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_idle("rst_wait");
      @(negedge clk) rst = 1'b0;
      txn(1'b0, 32'h3E8, 32'd0, 0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 9);
         if (k < 7) begin
            case ($urandom_range(0, 4))
               0: w = 30'(LO);
               1: w = 30'(LO + 1);
               2: w = 30'(HI - 1);
               3: w = 30'(HI);
               default: w = 30'($urandom_range(LO, HI));
            endcase
            a = {w, 2'b00};
         end else begin
            case ($urandom_range(0, 2))
               0: a = {30'($urandom_range(LO, HI)), 2'($urandom_range(1, 3))};
               1: a = {30'($urandom_range(0, LO - 1)), 2'b00};
               default: a = {30'($urandom_range(HI + 1, 32'h3FFF_FFFF)), 2'b00};
            endcase
         end
         wr = 1'($urandom_range(0, 1));
         if (!wr && k < 7 && !model.exists(a[31:2])) wr = 1'b1;
         txn(wr, a, $urandom, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
